prog_run_ctrl: RTL and testbench

PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

---
 rtl/prog_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
// Load/run/dump sequencer: streams a program into imem, holds the CPU in reset,
// runs it until END_PC or a cycle limit, then streams a window of dmem out.
module prog_run_ctrl #(
   parameter logic [31:0] END_PC     = 32'h78,
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DUMP_BASE  = 32,
   parameter int unsigned DUMP_WORDS = 96,
   parameter int unsigned RST_HOLD   = 3,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_reset,
   input  logic [31:0] cpu_pc,
   output logic        dmem_sel,
   output logic [31:0] dmem_raddr,
   input  logic [31:0] dmem_rdata,
   output logic        dump_valid,
   output logic [31:0] dump_data,
   input  logic        dump_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        trunc,
   output logic [31:0] run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DUMP,
      S_DONE
   } state_t;

   localparam logic [31:0] LD_LAST_IDX   = 32'(IMEM_WORDS - 1);
   localparam logic [31:0] DUMP_LAST_IDX = 32'(DUMP_WORDS - 1);
   localparam logic [31:0] DUMP_BASE_W   = 32'(DUMP_BASE);
   localparam logic [31:0] HOLD_LAST     = (RST_HOLD == 0) ? 32'd0 : 32'(RST_HOLD - 1);
   localparam logic [31:0] RUN_LIMIT     = 32'(MAX_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] ld_idx_q, ld_idx_d;
   logic [31:0] dump_idx_q, dump_idx_d;
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic [31:0] run_cycles_q, run_cycles_d;
   logic        timeout_q, timeout_d;
   logic        trunc_q, trunc_d;

   always_comb begin
      state_d      = state_q;
      ld_idx_d     = ld_idx_q;
      dump_idx_d   = dump_idx_q;
      hold_cnt_d   = hold_cnt_q;
      run_cycles_d = run_cycles_q;
      timeout_d    = timeout_q;
      trunc_d      = trunc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_LOAD;
               ld_idx_d     = '0;
               dump_idx_d   = '0;
               hold_cnt_d   = '0;
               run_cycles_d = '0;
               timeout_d    = 1'b0;
               trunc_d      = 1'b0;
            end
         end
         S_LOAD: begin
            if (ld_valid) begin
               if (ld_last || (ld_idx_q == LD_LAST_IDX)) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = '0;
                  trunc_d    = !ld_last;
               end
               // Saturate so the index never points past the last imem word.
               if (ld_idx_q != LD_LAST_IDX) begin
                  ld_idx_d = ld_idx_q + 32'd1;
               end
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 32'd1;
            end
         end
         S_RUN: begin
            // A PC match takes priority over the cycle limit and freezes the count.
            if (cpu_pc == END_PC) begin
               state_d = S_DUMP;
            end else if (run_cycles_q == RUN_LIMIT) begin
               state_d   = S_DUMP;
               timeout_d = 1'b1;
            end else begin
               run_cycles_d = run_cycles_q + 32'd1;
            end
         end
         S_DUMP: begin
            if (dump_ready) begin
               if (dump_idx_q == DUMP_LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  dump_idx_d = dump_idx_q + 32'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ld_idx_q     <= '0;
         dump_idx_q   <= '0;
         hold_cnt_q   <= '0;
         run_cycles_q <= '0;
         timeout_q    <= 1'b0;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_idx_q     <= ld_idx_d;
         dump_idx_q   <= dump_idx_d;
         hold_cnt_q   <= hold_cnt_d;
         run_cycles_q <= run_cycles_d;
         timeout_q    <= timeout_d;
         trunc_q      <= trunc_d;
      end
   end

   // The processor only leaves reset in RUN, so dmem is frozen while we dump it.
   assign ld_ready   = (state_q == S_LOAD);
   assign imem_we    = ld_ready & ld_valid;
   assign imem_addr  = ld_ready ? ld_idx_q : '0;
   assign imem_wdata = ld_ready ? ld_data : '0;
   assign cpu_reset  = (state_q != S_RUN);
   assign dmem_sel   = (state_q == S_DUMP);
   assign dmem_raddr = dmem_sel ? (DUMP_BASE_W + dump_idx_q) : '0;
   assign dump_valid = dmem_sel;
   assign dump_data  = dmem_sel ? dmem_rdata : '0;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign timeout    = timeout_q;
   assign trunc      = trunc_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: bench-side imem/dmem models, a scripted CPU PC,
// and one task per scenario with inline comparisons.
module tb_prog_run_ctrl;

   localparam logic [31:0] END_PC = 32'h78;
   localparam int MAX_CYC  = 100;
   localparam int DBASE    = 32;
   localparam int DWORDS   = 96;
   localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_data = '0;
   logic        ld_last = 1'b0;
   logic        ld_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic [31:0] cpu_pc = '0;
   logic        dmem_sel;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_rdata;
   logic        dump_valid;
   logic [31:0] dump_data;
   logic        dump_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        trunc;
   logic [31:0] run_cycles;

   int checks = 0;
   int errors = 0;

   logic [31:0] imem_mdl [0:63];
   logic [31:0] dmem_mdl [0:127];

   prog_run_ctrl #(.MAX_CYCLES(MAX_CYC)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .cpu_pc(cpu_pc),
      .dmem_sel(dmem_sel), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
      .busy(busy), .done(done), .timeout(timeout), .trunc(trunc), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   // Bench-side memories: imem captures writes, dmem answers reads combinationally.
   always @(posedge clk) begin
      if (imem_we && imem_addr < 32'd64) imem_mdl[imem_addr[5:0]] <= imem_wdata;
   end
   assign dmem_rdata = (dmem_raddr < 32'd128) ? dmem_mdl[dmem_raddr[6:0]] : 32'h0;

   function automatic logic [31:0] prog_word(input int i, input int seed);
      return 32'h0000_0013 + (32'(seed) << 24) + (32'(i) << 8);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_words(input int n, input bit set_last, input int seed, output int accepted);
      accepted = 0;
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = prog_word(i, seed);
         ld_last  = set_last && (i == n - 1);
         if (ld_ready !== 1'b1) break;
         tick();
         accepted++;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic measure_hold(output int cnt);
      cnt = 0;
      while (cpu_reset === 1'b1 && cnt < 20) begin
         cnt++;
         tick();
      end
   endtask

   // end_at < 0 never reaches END_PC; start_at >= 0 pulses start during that RUN cycle.
   task automatic run_program(input int end_at, input int start_at, output int run_len);
      run_len = 0;
      while (cpu_reset === 1'b0 && run_len < 300) begin
         cpu_pc = (run_len == end_at) ? END_PC : 32'h1000 + 32'(run_len) * 4;
         start  = (run_len == start_at);
         tick();
         start = 1'b0;
         run_len++;
      end
      cpu_pc = '0;
   endtask

   task automatic collect_dump(input bit random_ready, input int stop_after,
                               output int words, output int order_errs, output int stall_errs);
      bit          rdy;
      bit          prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      int          guard = 0;
      words = 0;
      order_errs = 0;
      stall_errs = 0;
      while (dump_valid === 1'b1 && words < stop_after && guard < 3000) begin
         rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         dump_ready = rdy;
         if (dump_data !== dmem_mdl[DBASE + words]) order_errs++;
         if (dmem_sel !== 1'b1 || dmem_raddr !== 32'(DBASE + words)) order_errs++;
         if (prev_stall && dump_data !== prev_data) stall_errs++;
         prev_data  = dump_data;
         prev_stall = !rdy;
         tick();
         if (rdy) words++;
         guard++;
      end
      dump_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({cpu_reset, busy, done, timeout, trunc} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 10000", {cpu_reset, busy, done, timeout, trunc});
      end
      checks++;
      if (run_cycles !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_run_cycles: got %0d expected 0", run_cycles);
      end
      ld_valid = 1'b1;
      #1;
      checks++;
      if ({ld_ready, imem_we, dmem_sel, dump_valid} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_handshakes: got %b expected 0000", {ld_ready, imem_we, dmem_sel, dump_valid});
      end
      ld_valid = 1'b0;
      tick();
   endtask

   task automatic test_normal_run();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      checks++;
      if ({busy, ld_ready, cpu_reset} !== 3'b111) begin
         errors++;
         $display("[TB] FAIL normal_enter_load: got %b expected 111", {busy, ld_ready, cpu_reset});
      end
      load_words(30, 1'b1, 1, acc);
      checks++;
      if (acc !== 30) begin
         errors++;
         $display("[TB] FAIL normal_accepted: got %0d expected 30", acc);
      end
      checks++;
      if (trunc !== 1'b0 || ld_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL normal_hold_entry: got trunc=%b ld_ready=%b expected 0 0", trunc, ld_ready);
      end
      checks++;
      if (imem_mdl[0] !== prog_word(0, 1) || imem_mdl[29] !== prog_word(29, 1) || imem_mdl[30] !== SENTINEL) begin
         errors++;
         $display("[TB] FAIL normal_imem: got %h %h %h expected %h %h %h", imem_mdl[0], imem_mdl[29],
                  imem_mdl[30], prog_word(0, 1), prog_word(29, 1), SENTINEL);
      end
      measure_hold(hold);
      checks++;
      if (hold !== 3) begin
         errors++;
         $display("[TB] FAIL normal_hold_cycles: got %0d expected 3", hold);
      end
      run_program(20, -1, rlen);
      checks++;
      if (rlen !== 21 || run_cycles !== 32'd20 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL normal_run: got len=%0d cycles=%0d timeout=%b expected 21 20 0", rlen, run_cycles, timeout);
      end
      collect_dump(1'b0, 1000, words, oerr, serr);
      checks++;
      if (words !== DWORDS || oerr !== 0) begin
         errors++;
         $display("[TB] FAIL normal_dump: got words=%0d order_errs=%0d expected 96 0", words, oerr);
      end
      checks++;
      if ({done, busy, cpu_reset, dump_valid, timeout} !== 5'b10100) begin
         errors++;
         $display("[TB] FAIL normal_done: got %b expected 10100", {done, busy, cpu_reset, dump_valid, timeout});
      end
   endtask

   task automatic test_trunc();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      checks++;
      if (run_cycles !== 32'd0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL trunc_start_clear: got cycles=%0d done=%b expected 0 0", run_cycles, done);
      end
      load_words(70, 1'b0, 2, acc);
      checks++;
      if (acc !== 64 || trunc !== 1'b1) begin
         errors++;
         $display("[TB] FAIL trunc_load: got accepted=%0d trunc=%b expected 64 1", acc, trunc);
      end
      checks++;
      if (imem_mdl[63] !== prog_word(63, 2) || imem_mdl[0] !== prog_word(0, 2)) begin
         errors++;
         $display("[TB] FAIL trunc_imem: got %h %h expected %h %h", imem_mdl[63], imem_mdl[0],
                  prog_word(63, 2), prog_word(0, 2));
      end
      measure_hold(hold);
      run_program(5, -1, rlen);
      collect_dump(1'b0, 1000, words, oerr, serr);
      checks++;
      if (done !== 1'b1 || trunc !== 1'b1 || run_cycles !== 32'd5) begin
         errors++;
         $display("[TB] FAIL trunc_hold_in_done: got done=%b trunc=%b cycles=%0d expected 1 1 5", done, trunc, run_cycles);
      end
   endtask

   task automatic test_limit_with_last();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      checks++;
      if (trunc !== 1'b0) begin
         errors++;
         $display("[TB] FAIL limit_trunc_cleared: got %b expected 0", trunc);
      end
      load_words(64, 1'b1, 3, acc);
      checks++;
      if (acc !== 64 || trunc !== 1'b0 || imem_mdl[63] !== prog_word(63, 3)) begin
         errors++;
         $display("[TB] FAIL limit_last: got accepted=%0d trunc=%b w63=%h expected 64 0 %h", acc, trunc,
                  imem_mdl[63], prog_word(63, 3));
      end
      measure_hold(hold);
      run_program(99, -1, rlen);
      checks++;
      if (rlen !== 100 || run_cycles !== 32'd99 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tie_end_pc_wins: got len=%0d cycles=%0d timeout=%b expected 100 99 0", rlen, run_cycles, timeout);
      end
      collect_dump(1'b0, 1000, words, oerr, serr);
   endtask

   task automatic test_timeout();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      load_words(5, 1'b1, 4, acc);
      measure_hold(hold);
      run_program(-1, -1, rlen);
      checks++;
      if (rlen !== 100 || run_cycles !== 32'd99 || timeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_run: got len=%0d cycles=%0d timeout=%b expected 100 99 1", rlen, run_cycles, timeout);
      end
      collect_dump(1'b0, 1000, words, oerr, serr);
      checks++;
      if (words !== DWORDS || oerr !== 0 || done !== 1'b1 || timeout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_dump: got words=%0d order_errs=%0d done=%b timeout=%b expected 96 0 1 1",
                  words, oerr, done, timeout);
      end
   endtask

   task automatic test_stall();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_timeout_cleared: got %b expected 0", timeout);
      end
      load_words(8, 1'b1, 5, acc);
      measure_hold(hold);
      run_program(0, -1, rlen);
      checks++;
      if (rlen !== 1 || run_cycles !== 32'd0) begin
         errors++;
         $display("[TB] FAIL stall_immediate_end: got len=%0d cycles=%0d expected 1 0", rlen, run_cycles);
      end
      collect_dump(1'b1, 1000, words, oerr, serr);
      checks++;
      if (words !== DWORDS || oerr !== 0 || serr !== 0 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_dump: got words=%0d order_errs=%0d stall_errs=%0d done=%b expected 96 0 0 1",
                  words, oerr, serr, done);
      end
   endtask

   task automatic test_start_ignored();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      load_words(6, 1'b1, 6, acc);
      measure_hold(hold);
      run_program(10, 5, rlen);
      checks++;
      if (rlen !== 11 || run_cycles !== 32'd10 || dump_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_in_run: got len=%0d cycles=%0d dump_valid=%b expected 11 10 1", rlen, run_cycles, dump_valid);
      end
      collect_dump(1'b0, 1000, words, oerr, serr);
      pulse_start();
      checks++;
      if ({busy, ld_ready, done, timeout, trunc} !== 5'b11000 || run_cycles !== 32'd0) begin
         errors++;
         $display("[TB] FAIL start_in_done: got %b cycles=%0d expected 11000 0", {busy, ld_ready, done, timeout, trunc}, run_cycles);
      end
      load_words(3, 1'b0, 7, acc);
      ld_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({ld_ready, imem_we, busy, cpu_reset} !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_mid_load: got %b expected 0001", {ld_ready, imem_we, busy, cpu_reset});
      end
      ld_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_dump();
      int acc, hold, rlen, words, oerr, serr;
      pulse_start();
      load_words(10, 1'b1, 8, acc);
      measure_hold(hold);
      run_program(3, -1, rlen);
      collect_dump(1'b0, 40, words, oerr, serr);
      checks++;
      if (words !== 40 || dump_valid !== 1'b1 || dmem_raddr !== 32'd72) begin
         errors++;
         $display("[TB] FAIL dump_word40: got words=%0d valid=%b raddr=%0d expected 40 1 72", words, dump_valid, dmem_raddr);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({dump_valid, dmem_sel, busy, done, cpu_reset} !== 5'b00001 || run_cycles !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_dump: got %b cycles=%0d expected 00001 0", {dump_valid, dmem_sel, busy, done, cpu_reset}, run_cycles);
      end
      pulse_start();
      load_words(12, 1'b1, 9, acc);
      measure_hold(hold);
      run_program(7, -1, rlen);
      collect_dump(1'b0, 1000, words, oerr, serr);
      checks++;
      if (acc !== 12 || hold !== 3 || run_cycles !== 32'd7 || words !== DWORDS || oerr !== 0 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_after_reset: got acc=%0d hold=%0d cycles=%0d words=%0d oerr=%0d done=%b expected 12 3 7 96 0 1",
                  acc, hold, run_cycles, words, oerr, done);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem_mdl[i] = SENTINEL;
      for (int i = 0; i < 128; i++) dmem_mdl[i] = 32'hC0DE_0000 + 32'(i) * 32'd7 + (32'(i) << 20);
      @(negedge clk);
      test_reset();
      test_normal_run();
      test_trunc();
      test_limit_with_last();
      test_timeout();
      test_stall();
      test_start_ignored();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
